// File: rtl/sspi_pkg.sv
// Shared types and defaults for the Wishbone-to-reg-bus bridge.
// Holds the FSM state encoding, the timeout default and the counter width.
package sspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned CNT_W           = 10;

endpackage

// File: rtl/sspi_reg_bridge_if.sv
// Bundle of the Wishbone slave side and reg-bus master side of the bridge.
// Modports are named from the bridge's point of view.
interface sspi_reg_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [10:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        reg_slv_cs;
  logic        reg_slv_wr;
  logic [8:0]  reg_slv_addr;
  logic [31:0] reg_slv_wdata;
  logic [3:0]  reg_slv_be;
  logic [31:0] reg_slv_rdata;
  logic        reg_slv_ack;
  logic        timeout_evt;

  modport wb_slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, timeout_evt
  );

  modport reg_master (
    output reg_slv_cs, reg_slv_wr, reg_slv_addr, reg_slv_wdata, reg_slv_be,
    input  reg_slv_rdata, reg_slv_ack
  );
endinterface

// File: rtl/sspi_bridge_tmo.sv
// Timeout counter for the WAIT state: clears on entry, counts idle WAIT cycles,
// and flags terminal count once TERM-1 cycles have elapsed without an ack.
module sspi_bridge_tmo
  import sspi_pkg::*;
#(
  parameter int unsigned TERM = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(TERM - 1));

endmodule

// File: rtl/sspi_reg_bridge.sv
// Wishbone slave to simple reg-bus master bridge with a per-access timeout.
// Every output is a flop, so no wbs_* input reaches a reg_slv_* output combinationally.
module sspi_reg_bridge
  import sspi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        app_clk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [10:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_slv_cs,
  output logic        reg_slv_wr,
  output logic [8:0]  reg_slv_addr,
  output logic [31:0] reg_slv_wdata,
  output logic [3:0]  reg_slv_be,
  input  logic [31:0] reg_slv_rdata,
  input  logic        reg_slv_ack,
  output logic        timeout_evt,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken when cyc&stb are both high in IDLE; the reg
  // slave completes it with a single-cycle ack while cs is high; the response
  // (ack or err) is a single-cycle pulse, suppressed if cyc dropped during WAIT.

  state_e      state_q, state_d;
  logic        cs_q, cs_d, wr_q, wr_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, dat_q, dat_d;
  logic [3:0]  be_q, be_d;
  logic        ack_q, ack_d, err_q, err_d, tmo_q, tmo_d;
  logic        lost_q, lost_d;
  logic        cnt_clr, cnt_en, cnt_tc, abort;
  logic        unused_adr_lsb;

  assign unused_adr_lsb = ^wbs_adr_i[1:0];
  assign abort          = lost_q | ~wbs_cyc_i;

  sspi_bridge_tmo #(.TERM(TIMEOUT_CYC)) u_tmo (
    .clk   (app_clk),
    .rst_n (reset_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    dat_d   = dat_q;
    lost_d  = lost_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = ST_WAIT;
          cs_d    = 1'b1;
          wr_d    = wbs_we_i;
          addr_d  = wbs_adr_i[10:2];
          wdata_d = wbs_dat_i;
          be_d    = wbs_sel_i;
          lost_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) lost_d = 1'b1;
        // Ack beats a timeout landing in the same cycle.
        if (reg_slv_ack) begin
          state_d = ST_RESP;
          cs_d    = 1'b0;
          dat_d   = wr_q ? 32'h0 : reg_slv_rdata;
          ack_d   = ~abort;
        end else if (cnt_tc) begin
          state_d = ST_RESP;
          cs_d    = 1'b0;
          dat_d   = 32'h0;
          err_d   = ~abort;
          tmo_d   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      dat_q   <= '0;
      lost_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      dat_q   <= dat_d;
      lost_q  <= lost_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wbs_dat_o     = dat_q;
  assign wbs_ack_o     = ack_q;
  assign wbs_err_o     = err_q;
  assign reg_slv_cs    = cs_q;
  assign reg_slv_wr    = wr_q;
  assign reg_slv_addr  = addr_q;
  assign reg_slv_wdata = wdata_q;
  assign reg_slv_be    = be_q;
  assign timeout_evt   = tmo_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/sspi_reg_bridge.md
SSPI_REG_BRIDGE -- requirements
Module: sspi_reg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the number of WAIT cycles without reg_slv_ack before an error is returned; legal range 2..1023.
REQ-002 SHALL have port app_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have Wishbone slave inputs: wbs_cyc_i 1; wbs_stb_i 1; wbs_we_i 1; wbs_adr_i 11 (byte address); wbs_dat_i 32; wbs_sel_i 4.
REQ-005 SHALL have Wishbone slave outputs: wbs_dat_o 32; wbs_ack_o 1; wbs_err_o 1.
REQ-006 SHALL have reg-bus master outputs: reg_slv_cs 1; reg_slv_wr 1; reg_slv_addr 9; reg_slv_wdata 32; reg_slv_be 4.
REQ-007 SHALL have reg-bus master inputs: reg_slv_rdata 32; reg_slv_ack 1.
REQ-008 SHALL have output timeout_evt, 1 bit: one-cycle pulse on each timeout.

Function
REQ-009 SHALL implement states IDLE, WAIT, RESP.
REQ-010 In IDLE, when wbs_cyc_i and wbs_stb_i are both 1, the block SHALL register the request and go to WAIT. Captured fields: we, adr[10:2] mapped to reg_slv_addr, dat_i and sel_i.
REQ-011 reg_slv_cs SHALL be registered and equal 1 exactly while in WAIT. The first cs cycle is the cycle after acceptance.
REQ-012 reg_slv_wr, reg_slv_addr, reg_slv_wdata and reg_slv_be SHALL hold their captured values from acceptance until the next acceptance.
REQ-013 reg_slv_ack SHALL be honoured only in WAIT and ignored elsewhere.
REQ-014 In WAIT, reg_slv_ack=1 SHALL capture reg_slv_rdata into wbs_dat_o (reads only; writes leave 0), drop cs next cycle and go to RESP.
REQ-015 RESP SHALL last one cycle: wbs_ack_o=1 for a normal completion, or wbs_err_o=1 for a timeout. It then SHALL return to IDLE.
REQ-016 Latency: if the request is accepted at edge T and reg_slv_ack is sampled at edge T+k (k>=1), wbs_ack_o SHALL be high during cycle T+k+1. Minimum request-to-ack latency is 2 cycles.
REQ-017 A 10-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-018 When the counter reaches TIMEOUT_CYC-1 with no ack, the block SHALL drop cs, load wbs_dat_o with 0, pulse timeout_evt and go to RESP with err.
REQ-019 If reg_slv_ack and the timeout condition occur in the same cycle, the ack SHALL win: normal completion, no err, no timeout_evt.
REQ-020 If wbs_cyc_i drops while in WAIT, the reg transfer SHALL still complete or time out. RESP SHALL then drive neither ack nor err, but timeout_evt still pulses.
REQ-021 wbs_ack_o and wbs_err_o SHALL never both be 1, and SHALL never be 1 outside RESP.
REQ-022 In IDLE, wbs_stb_i without wbs_cyc_i SHALL be ignored.
REQ-023 Back-to-back: a new request present in the cycle after RESP SHALL be accepted, so one request is served every 3 cycles minimum.

Reset
REQ-024 While reset_n=0 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-025 During reset, reg_slv_cs, reg_slv_wr, wbs_ack_o, wbs_err_o and timeout_evt SHALL be 0, and all data/address/be outputs SHALL be 0.
REQ-026 Reset asserted mid-WAIT SHALL abandon the transfer with cs low after that edge and no ack/err response afterwards.

Structure
REQ-027 FSM state typedef and the TIMEOUT_CYC default SHALL live in shared package sspi_pkg.
REQ-028 The timeout counter SHALL be a sub-module named sspi_bridge_tmo (clear, enable, terminal-count output).
REQ-029 The block SHALL contain no combinational path from any wbs_* input to any reg_slv_* output.

Verification
REQ-030 Write test: write adr=0x104, dat=0xA5A5_1234, sel=0xF; slave acks on the 2nd cs cycle -> cs for 2 cycles, reg_slv_addr=0x041, wr=1, wbs_ack_o 1 cycle, no err.
REQ-031 Read test: read adr=0x008; slave returns 0xCAFE_0001 with ack on the 1st cs cycle -> wbs_dat_o=0xCAFE_0001 with wbs_ack_o, exactly 2 cycles after acceptance.
REQ-032 Timeout test: TIMEOUT_CYC=4, slave never acks -> cs high 4 cycles, timeout_evt pulse, wbs_err_o 1 cycle, wbs_dat_o=0.
REQ-033 Tie test: TIMEOUT_CYC=4, ack arrives in the 4th WAIT cycle -> wbs_ack_o=1, wbs_err_o=0, no timeout_evt.
REQ-034 Abort and reset tests: cyc dropped in WAIT, then slave acks -> no wbs ack/err. Separately, reset_n=0 in WAIT -> cs=0 next edge and no response.
REQ-035 Throughput test: three back-to-back reads with immediate slave ack -> three wbs_ack_o pulses spaced 3 cycles apart.
